pipeline_ctrl_sequencer: RTL and testbench
==========================================

// Module: pipeline_ctrl_sequencer
// PURPOSE
//  Central pipeline controller. Merges the load-use stall from the hazard/forwarding unit,
//  taken-branch flush from EX, and external interrupt entry/exit into per-stage enable and
//  flush controls. Sequences interrupt entry (drain -> push PC -> load vector) with an FSM.
//  Sits beside the hazard/forwarding unit and drives PC, IF/ID, ID/EX and EX/MEM registers.
// PARAMETERS
//  DRAIN_CYCLES  3  bubble cycles issued before PC push on interrupt entry (>=1)
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  hz_stall     in   1  load-use stall request for the instruction in EX
//  br_taken     in   1  branch/jump resolved taken in EX (PC mux already selects target)
//  intr         in   1  external interrupt request, level, synchronous to clk
//  rti_ex       in   1  return-from-interrupt instruction in EX
//  en_pc        out  1  PC register load enable
//  en_if_id     out  1  IF/ID register enable
//  en_id_ex     out  1  ID/EX register enable
//  flush_if_id  out  1  IF/ID loads NOP
//  flush_id_ex  out  1  ID/EX loads NOP
//  flush_ex_mem out  1  EX/MEM loads NOP (bubble behind a stalled EX instruction)
//  int_push     out  1  push current PC onto stack this cycle
//  int_vec_sel  out  1  PC mux selects interrupt vector this cycle
//  int_ack      out  1  one-cycle acknowledge to interrupt source
//  in_isr       out  1  registered: handler active, further interrupts held pending
// BEHAVIOUR
//  State: FSM {RUN, DRAIN, PUSH, VEC}; drain counter width $clog2(DRAIN_CYCLES+1);
//  registered int_pend, in_isr. Outputs other than in_isr are combinational from state+inputs.
//  Reset (rst=1): state<=RUN, cnt<=0, int_pend<=0, in_isr<=0. While rst=1 outputs forced:
//   en_*=0, flush_*=1, int_push=int_vec_sel=int_ack=0, in_isr=0.
//  Default (RUN, no event): en_*=1, flush_*=0, int_*=0.
//  int_pend <= 1 whenever intr=1 (any state); cleared only in VEC. Latched while in_isr=1.
//  RUN priority (highest first):
//   1 hz_stall: en_pc=en_if_id=en_id_ex=0, flush_ex_mem=1; br_taken, rti_ex ignored (re-evaluated
//     next cycle); no state change.
//   2 br_taken: en_*=1, flush_if_id=flush_id_ex=1.
//   3 rti_ex: in_isr<=0 next edge; normal enables.
//   4 int_pend & ~in_isr: -> DRAIN, cnt<=DRAIN_CYCLES; this cycle en_pc=0, flush_if_id=1.
//  br_taken and rti_ex in the same cycle: both honoured (flush and clear in_isr).
//  DRAIN: en_pc=0, flush_if_id=1, en_if_id=en_id_ex=1 (older instructions retire).
//   hz_stall: stall outputs as RUN rule 1 (flush_if_id=0), cnt held.
//   br_taken (no stall): en_pc=1, flush_if_id=flush_id_ex=1, cnt<=DRAIN_CYCLES (restart;
//     branch target becomes return PC).
//   else cnt<=cnt-1; when cnt==1 -> PUSH. cnt never wraps below 0.
//  PUSH (1 cycle): int_push=1, en_pc=0, flush_if_id=1; -> VEC.
//  VEC (1 cycle): int_vec_sel=1, en_pc=1, int_ack=1, flush_if_id=1; in_isr<=1, int_pend<=0;
//   -> RUN. intr high during VEC re-sets int_pend (serviced after RTI).
//  Entry latency: intr sampled at edge N -> int_push at cycle N+1+DRAIN_CYCLES+1 -> vector
//   fetched cycle after int_vec_sel, absent stalls/branches.
//  rst mid-sequence: returns to RUN next edge; no push/ack emitted.
// TESTING
//  hz_stall=1 one cycle with br_taken=1 in RUN -> en_pc/en_if_id/en_id_ex=0, flush_ex_mem=1,
//   no flushes of IF/ID or ID/EX; next cycle br_taken=1 alone -> flush_if_id=flush_id_ex=1.
//  intr pulse 1 cycle, DRAIN_CYCLES=3, quiet pipeline -> 1 RUN-exit cycle + 3 DRAIN cycles,
//   then int_push=1 exactly 1 cycle, then int_vec_sel=int_ack=1 1 cycle, in_isr=1 after.
//  In DRAIN cnt=2, hz_stall 2 cycles -> cnt holds 2, flush_ex_mem=1 both cycles; push delayed 2.
//  In DRAIN br_taken=1 -> en_pc=1, both flushes, cnt reloads 3; push follows 3 clean cycles.
//  in_isr=1, intr=1 -> no DRAIN; rti_ex=1 -> in_isr=0 next edge, DRAIN entered the cycle after.
//  rst=1 during PUSH -> all en=0, flushes=1, next state RUN, int_pend=0, no int_ack ever seen.

Source files
------------

// File: rtl/pipeline_ctrl_sequencer.sv
// ============================================================================
// Module      : pipeline_ctrl_sequencer
// Description : Central pipeline controller. Merges load-use stall, taken
//               branch flush and interrupt entry/exit into per-stage enable
//               and flush controls. Interrupt entry is drain -> push -> vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl_sequencer #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic hz_stall,
    input  logic br_taken,
    input  logic intr,
    input  logic rti_ex,
    output logic en_pc,
    output logic en_if_id,
    output logic en_id_ex,
    output logic flush_if_id,
    output logic flush_id_ex,
    output logic flush_ex_mem,
    output logic int_push,
    output logic int_vec_sel,
    output logic int_ack,
    output logic in_isr
);

    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] C_CNT_LOAD = CW'(DRAIN_CYCLES);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_PUSH  = 2'd2;
    localparam logic [1:0] S_VEC   = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_int_pend;
    logic          w_int_pend_nxt;
    logic          r_in_isr;
    logic          w_in_isr_nxt;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_cnt      <= '0;
            r_int_pend <= 1'b0;
            r_in_isr   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_int_pend <= w_int_pend_nxt;
            r_in_isr   <= w_in_isr_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_in_isr_nxt   = r_in_isr;
        w_int_pend_nxt = r_int_pend | intr;

        case (r_state)
            S_RUN: begin
                // A stall defers every other event; they are re-evaluated next cycle.
                if (!hz_stall) begin
                    if (br_taken || rti_ex) begin
                        if (rti_ex) begin
                            w_in_isr_nxt = 1'b0;
                        end
                    end else if (r_int_pend && !r_in_isr) begin
                        w_state_nxt = S_DRAIN;
                        w_cnt_nxt   = C_CNT_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                if (!hz_stall) begin
                    if (br_taken) begin
                        // Branch target becomes the return PC, so drain restarts.
                        w_cnt_nxt = C_CNT_LOAD;
                    end else begin
                        if (r_cnt != '0) begin
                            w_cnt_nxt = r_cnt - C_CNT_ONE;
                        end
                        if (r_cnt <= C_CNT_ONE) begin
                            w_state_nxt = S_PUSH;
                        end
                    end
                end
            end
            S_PUSH: begin
                w_state_nxt = S_VEC;
            end
            S_VEC: begin
                w_state_nxt    = S_RUN;
                w_in_isr_nxt   = 1'b1;
                w_int_pend_nxt = intr;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        en_pc        = 1'b1;
        en_if_id     = 1'b1;
        en_id_ex     = 1'b1;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        int_push     = 1'b0;
        int_vec_sel  = 1'b0;
        int_ack      = 1'b0;

        if (rst) begin
            en_pc        = 1'b0;
            en_if_id     = 1'b0;
            en_id_ex     = 1'b0;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (hz_stall) begin
                        en_pc        = 1'b0;
                        en_if_id     = 1'b0;
                        en_id_ex     = 1'b0;
                        flush_ex_mem = 1'b1;
                    end else if (br_taken) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (!rti_ex && r_int_pend && !r_in_isr) begin
                        en_pc       = 1'b0;
                        flush_if_id = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (hz_stall) begin
                        en_pc        = 1'b0;
                        en_if_id     = 1'b0;
                        en_id_ex     = 1'b0;
                        flush_ex_mem = 1'b1;
                    end else if (br_taken) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else begin
                        en_pc       = 1'b0;
                        flush_if_id = 1'b1;
                    end
                end
                S_PUSH: begin
                    int_push    = 1'b1;
                    en_pc       = 1'b0;
                    flush_if_id = 1'b1;
                end
                S_VEC: begin
                    int_vec_sel = 1'b1;
                    int_ack     = 1'b1;
                    flush_if_id = 1'b1;
                end
                default: begin
                    en_pc = 1'b1;
                end
            endcase
        end
    end

    assign in_isr = r_in_isr & ~rst;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl_sequencer.sv
// ============================================================================
// Module      : tb_pipeline_ctrl_sequencer
// Description : Self-checking bench: directed vector table, corner-case
//               sequences and random stimulus against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl_sequencer;

    localparam int D = 3;

    logic clk = 1'b0;
    logic rst, hz_stall, br_taken, intr, rti_ex;
    logic en_pc, en_if_id, en_id_ex, flush_if_id, flush_id_ex, flush_ex_mem;
    logic int_push, int_vec_sel, int_ack, in_isr;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_ctrl_sequencer #(.DRAIN_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .hz_stall(hz_stall), .br_taken(br_taken),
        .intr(intr), .rti_ex(rti_ex),
        .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem), .int_push(int_push),
        .int_vec_sel(int_vec_sel), .int_ack(int_ack), .in_isr(in_isr)
    );

    always #5 clk = ~clk;

    // Behavioural model: pending/handler flags, remaining drain bubbles and
    // one-shot markers for the push and vector cycles.
    bit m_pend = 0, m_isr = 0, m_push = 0, m_vec = 0;
    int m_drain = 0;

    // Packing: {en_pc,en_if_id,en_id_ex,flush_if_id,flush_id_ex,flush_ex_mem,push,vec,ack,in_isr}
    function automatic logic [9:0] model_out(bit r, bit h, bit b, bit t);
        bit ep = 1, ei = 1, ee = 1, fi = 0, fe = 0, fm = 0, pu = 0, vs = 0, ak = 0;
        if (r) return 10'b000_111_000_0;
        if (m_push) begin
            pu = 1; ep = 0; fi = 1;
        end else if (m_vec) begin
            vs = 1; ak = 1; fi = 1;
        end else if (m_drain > 0) begin
            if (h)      begin ep = 0; ei = 0; ee = 0; fm = 1; end
            else if (b) begin fi = 1; fe = 1; end
            else        begin ep = 0; fi = 1; end
        end else begin
            if (h)                              begin ep = 0; ei = 0; ee = 0; fm = 1; end
            else if (b)                         begin fi = 1; fe = 1; end
            else if (!t && m_pend && !m_isr)    begin ep = 0; fi = 1; end
        end
        return {ep, ei, ee, fi, fe, fm, pu, vs, ak, m_isr};
    endfunction

    task automatic model_advance(bit r, bit h, bit b, bit i, bit t);
        bit was_vec;
        if (r) begin
            m_pend = 0; m_isr = 0; m_push = 0; m_vec = 0; m_drain = 0;
            return;
        end
        was_vec = m_vec;
        if (m_push) begin
            m_push = 0; m_vec = 1;
        end else if (m_vec) begin
            m_vec = 0; m_isr = 1;
        end else if (m_drain > 0) begin
            if (!h) begin
                if (b) m_drain = D;
                else begin
                    m_drain = m_drain - 1;
                    if (m_drain == 0) m_push = 1;
                end
            end
        end else if (!h) begin
            if (b || t) begin
                if (t) m_isr = 0;
            end else if (m_pend && !m_isr) begin
                m_drain = D;
            end
        end
        m_pend = was_vec ? i : (m_pend | i);
    endtask

    task automatic check_vec(input string nm, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // One clock cycle: drive, sample mid-cycle, then let the edge pass.
    task automatic cyc(input bit r, input bit h, input bit b, input bit i, input bit t,
                       output logic [9:0] got, output logic [9:0] exp);
        rst = r; hz_stall = h; br_taken = b; intr = i; rti_ex = t;
        @(negedge clk);
        got = {en_pc, en_if_id, en_id_ex, flush_if_id, flush_id_ex, flush_ex_mem,
               int_push, int_vec_sel, int_ack, in_isr};
        exp = model_out(r, h, b, t);
        @(posedge clk);
        model_advance(r, h, b, i, t);
        #1;
    endtask

    task automatic cyc_chk(input string nm, input bit r, input bit h, input bit b,
                           input bit i, input bit t, output logic [9:0] got);
        logic [9:0] exp;
        cyc(r, h, b, i, t, got, exp);
        check_vec(nm, got, exp);
    endtask

    typedef struct {
        bit r, h, b, i, t;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] got, exp;
        int push_at, ack_seen;

        //          r  h  b  i  t   expected
        tbl[0]  = '{1, 0, 0, 0, 0, 10'b000_111_000_0};
        tbl[1]  = '{0, 0, 0, 0, 0, 10'b111_000_000_0};
        tbl[2]  = '{0, 1, 1, 0, 0, 10'b000_001_000_0};
        tbl[3]  = '{0, 0, 1, 0, 0, 10'b111_110_000_0};
        tbl[4]  = '{0, 0, 0, 1, 0, 10'b111_000_000_0};
        tbl[5]  = '{0, 0, 0, 0, 0, 10'b011_100_000_0};
        tbl[6]  = '{0, 0, 0, 0, 0, 10'b011_100_000_0};
        tbl[7]  = '{0, 0, 0, 0, 0, 10'b011_100_000_0};
        tbl[8]  = '{0, 0, 0, 0, 0, 10'b011_100_000_0};
        tbl[9]  = '{0, 0, 0, 0, 0, 10'b011_100_100_0};
        tbl[10] = '{0, 0, 0, 0, 0, 10'b111_100_011_0};
        tbl[11] = '{0, 0, 0, 0, 0, 10'b111_000_000_1};
        tbl[12] = '{0, 0, 0, 1, 0, 10'b111_000_000_1};
        tbl[13] = '{0, 0, 0, 0, 0, 10'b111_000_000_1};
        tbl[14] = '{0, 0, 0, 0, 1, 10'b111_000_000_1};
        tbl[15] = '{0, 0, 0, 0, 0, 10'b011_100_000_0};
        tbl[16] = '{1, 0, 0, 0, 0, 10'b000_111_000_0};
        tbl[17] = '{0, 0, 0, 0, 0, 10'b111_000_000_0};

        rst = 1; hz_stall = 0; br_taken = 0; intr = 0; rti_ex = 0;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 18; k++) begin
            cyc(tbl[k].r, tbl[k].h, tbl[k].b, tbl[k].i, tbl[k].t, got, exp);
            check_vec($sformatf("table[%0d]", k), got, tbl[k].exp);
        end

        // Stall while draining with cnt==2: push slips by two cycles.
        cyc_chk("stall_rst", 1, 0, 0, 0, 0, got);
        cyc_chk("stall_intr", 0, 0, 0, 1, 0, got);
        cyc_chk("stall_exit", 0, 0, 0, 0, 0, got);
        cyc_chk("stall_cnt3", 0, 0, 0, 0, 0, got);
        cyc_chk("stall_hz1", 0, 1, 0, 0, 0, got);
        cyc_chk("stall_hz2", 0, 1, 0, 0, 0, got);
        push_at = -1;
        for (int k = 5; k < 20 && push_at < 0; k++) begin
            cyc_chk("stall_wait", 0, 0, 0, 0, 0, got);
            if (got[3]) push_at = k;
        end
        check_int("push_after_stall", push_at, 7);

        // Branch in the first drain cycle restarts the drain count.
        cyc_chk("br_rst", 1, 0, 0, 0, 0, got);
        cyc_chk("br_intr", 0, 0, 0, 1, 0, got);
        cyc_chk("br_exit", 0, 0, 0, 0, 0, got);
        cyc_chk("br_drain", 0, 0, 1, 0, 0, got);
        check_vec("br_drain_outs", got, 10'b111_110_000_0);
        push_at = -1;
        for (int k = 3; k < 20 && push_at < 0; k++) begin
            cyc_chk("br_wait", 0, 0, 0, 0, 0, got);
            if (got[3]) push_at = k;
        end
        check_int("push_after_branch", push_at, 6);

        // Reset asserted in the push cycle: no acknowledge may follow.
        cyc_chk("rp_rst", 1, 0, 0, 0, 0, got);
        cyc_chk("rp_intr", 0, 0, 0, 1, 0, got);
        for (int k = 1; k < 5; k++) cyc_chk("rp_drain", 0, 0, 0, 0, 0, got);
        cyc_chk("rp_push_rst", 1, 0, 0, 0, 0, got);
        check_vec("rp_forced", got, 10'b000_111_000_0);
        ack_seen = 0;
        for (int k = 0; k < 8; k++) begin
            cyc_chk("rp_after", 0, 0, 0, 0, 0, got);
            if (got[1]) ack_seen++;
        end
        check_int("rp_no_ack", ack_seen, 0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cyc_chk("random", ($urandom_range(63) == 0), ($urandom_range(4) == 0),
                    ($urandom_range(5) == 0), ($urandom_range(7) == 0),
                    ($urandom_range(9) == 0), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
